// File: rtl/bcd_countdown_timer.sv
// Loadable BCD down-counter with IDLE/RUN/PAUSED/EXPIRED control; all outputs registered, 1-cycle latency.
// No backpressure: every input is sampled each clk edge with priority reset > load > pause > start > tick.
module bcd_countdown_timer #(
    parameter  int DIGITS = 3,
    localparam int W      = 4 * DIGITS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         start,
    input  logic         pause,
    output logic [W-1:0] q,
    output logic         running,
    output logic         done,
    output logic         load_err
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_PAUSED  = 2'd2,
        S_EXPIRED = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] q_q, q_d;
    logic         running_q, running_d;
    logic         done_q, done_d;
    logic         load_err_q, load_err_d;

    logic load_valid;
    logic q_zero, q_one;
    logic do_load, bad_load, do_pause, do_start, do_tick;

    // Ripple-borrow decrement; only called when the count is nonzero.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    always_comb begin
        load_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_valid = 1'b0;
        end
    end

    assign q_zero   = (q_q == '0);
    assign q_one    = (q_q == W'(1));
    assign do_load  = load && load_valid;
    assign bad_load = load && !load_valid;
    assign do_pause = !load && pause && (state_q == S_RUN);
    assign do_start = !load && start && ((state_q == S_IDLE) || (state_q == S_PAUSED));
    assign do_tick  = !load && !do_pause && tick && (state_q == S_RUN) && !q_zero;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (do_load) begin
            state_d = S_IDLE;
        end else if (do_pause) begin
            state_d = S_PAUSED;
        end else if (do_start) begin
            state_d = q_zero ? S_EXPIRED : S_RUN;
        end else if (do_tick && q_one) begin
            state_d = S_EXPIRED;
        end
    end

    always_comb begin
        q_d        = q_q;
        done_d     = 1'b0;
        load_err_d = bad_load;
        if (do_load) begin
            q_d = load_val;
        end else if (do_start) begin
            done_d = q_zero;
        end else if (do_tick) begin
            q_d    = bcd_dec(q_q);
            done_d = q_one;
        end
        running_d = (state_d == S_RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q        <= '0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            running_q  <= running_d;
            done_q     <= done_d;
            load_err_q <= load_err_d;
        end
    end

    assign q        = q_q;
    assign running  = running_q;
    assign done     = done_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: integer-valued reference model feeds an expectation queue,
// a monitor pops one entry per clock and compares q/running/done/load_err.
module tb_bcd_countdown_timer;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         tick = 1'b0;
    logic         load = 1'b0;
    logic [W-1:0] load_val = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] q;
    logic         running;
    logic         done;
    logic         load_err;

    bcd_countdown_timer #(.DIGITS(DIGITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .pause    (pause),
        .q        (q),
        .running  (running),
        .done     (done),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] q;
        logic         running;
        logic         done;
        logic         load_err;
    } exp_t;

    exp_t exp_q[$];
    int   tests  = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   done_seen = 0;

    // Reference model: count as a plain integer, state as 0=idle 1=run 2=paused 3=expired.
    int m_cnt = 0;
    int m_st  = 0;

    function automatic logic [W-1:0] int2bcd(input int v);
        logic [W-1:0] r;
        int           x;
        x = v;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] b);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic bit is_bcd(input logic [W-1:0] b);
        for (int i = 0; i < DIGITS; i++) begin
            if (b[4*i +: 4] > 4'd9) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic drive(input logic r, input logic ld, input logic [W-1:0] lv,
                         input logic s, input logic p, input logic t);
        exp_t e;
        bit   d_exp;
        bit   le_exp;
        @(negedge clk);
        reset = r; load = ld; load_val = lv; start = s; pause = p; tick = t;
        d_exp  = 1'b0;
        le_exp = 1'b0;
        if (r) begin
            m_cnt = 0;
            m_st  = 0;
        end else if (ld) begin
            if (is_bcd(lv)) begin
                m_cnt = bcd2int(lv);
                m_st  = 0;
            end else begin
                le_exp = 1'b1;
            end
        end else if (p && m_st == 1) begin
            m_st = 2;
        end else if (s && (m_st == 0 || m_st == 2)) begin
            if (m_cnt == 0) begin
                m_st  = 3;
                d_exp = 1'b1;
            end else begin
                m_st = 1;
            end
        end else if (t && m_st == 1 && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_st  = 3;
                d_exp = 1'b1;
            end
        end
        e.q        = int2bcd(m_cnt);
        e.running  = (m_st == 1);
        e.done     = d_exp;
        e.load_err = le_exp;
        exp_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 0);
    endtask

    task automatic do_load(input logic [W-1:0] v);
        drive(0, 1, v, 0, 0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, '0, 0, 0, 1);
    endtask

    // Monitor: one expectation per clock, compared just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                cyc++;
                tests += 4;
                if (q !== e.q) begin
                    fails++;
                    $display("FAIL q cycle %0d: got %h expected %h", cyc, q, e.q);
                end
                if (running !== e.running) begin
                    fails++;
                    $display("FAIL running cycle %0d: got %b expected %b", cyc, running, e.running);
                end
                if (done !== e.done) begin
                    fails++;
                    $display("FAIL done cycle %0d: got %b expected %b", cyc, done, e.done);
                end
                if (load_err !== e.load_err) begin
                    fails++;
                    $display("FAIL load_err cycle %0d: got %b expected %b", cyc, load_err, e.load_err);
                end
                if (done === 1'b1) done_seen++;
            end
        end
    end

    int done_before;

    initial begin
        // Reset state, then start alone from zero goes straight to expiry.
        drive(1, 0, '0, 0, 0, 0);
        drive(1, 0, '0, 1, 1, 1);
        drive(0, 0, '0, 1, 0, 0);
        idle(2);

        // Two-digit borrow at 100 -> 099.
        do_load(12'h105);
        drive(0, 0, '0, 1, 0, 0);
        ticks(6);

        // Expiry from 002 and stuck at zero afterwards.
        do_load(12'h002);
        drive(0, 0, '0, 1, 0, 0);
        ticks(2);
        ticks(3);
        drive(0, 0, '0, 1, 0, 1);

        // Rejected load leaves everything alone, including an invalid units nibble.
        do_load(12'h1A3);
        do_load(12'h00F);
        idle(1);

        // Pause beats tick; ticks while paused ignored; resume.
        do_load(12'h050);
        drive(0, 0, '0, 1, 0, 0);
        ticks(1);
        drive(0, 0, '0, 0, 1, 1);
        ticks(3);
        drive(0, 0, '0, 1, 0, 0);
        ticks(1);
        drive(0, 0, '0, 1, 1, 1);

        // Load beats start, then start runs.
        do_load(12'h999);
        drive(0, 1, 12'h010, 1, 0, 0);
        drive(0, 0, '0, 1, 0, 0);
        ticks(2);

        // Full-range countdown: exactly one done, on tick 999.
        do_load(12'h999);
        drive(0, 0, '0, 1, 0, 0);
        ticks(998);
        idle(2);
        done_before = done_seen;
        ticks(1);
        ticks(2);
        idle(2);
        tests++;
        if (done_seen - done_before != 1) begin
            fails++;
            $display("FAIL done_count_999: got %0d pulses expected 1", done_seen - done_before);
        end

        // Reset mid-run at 500 abandons the count without done.
        do_load(12'h999);
        drive(0, 0, '0, 1, 0, 0);
        ticks(499);
        drive(1, 0, '0, 1, 0, 1);
        ticks(2);
        drive(0, 0, '0, 1, 0, 0);

        // Randomized mixture of all inputs.
        for (int i = 0; i < 1500; i++) begin
            logic [W-1:0] lv;
            logic r, ld, s, p, t;
            r  = ($urandom_range(0, 99) == 0);
            ld = ($urandom_range(0, 19) == 0);
            case ($urandom_range(0, 3))
                0:       lv = W'($urandom);
                1:       lv = int2bcd($urandom_range(0, 999));
                default: lv = int2bcd($urandom_range(0, 15));
            endcase
            s = ($urandom_range(0, 5) == 0);
            p = ($urandom_range(0, 9) == 0);
            t = ($urandom_range(0, 1) == 1);
            drive(r, ld, lv, s, p, t);
        end

        idle(1);
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_countdown_timer.md
BCD_COUNTDOWN_TIMER -- requirements
Module: bcd_countdown_timer

Interface
REQ-001 Parameter: DIGITS, 3, number of cascaded BCD decade digits (1..8); W = 4*DIGITS.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 tick  input  1  slow count enable, one-cycle qualifier.
REQ-005 load  input  1  parallel-load strobe.
REQ-006 load_val  input  W  BCD preset; nibble i = digit i; nibble 0 = units.
REQ-007 start  input  1  begin or resume countdown.
REQ-008 pause  input  1  suspend countdown.
REQ-009 q  output  W  current BCD count, registered.
REQ-010 running  output  1  high exactly while state == RUN.
REQ-011 done  output  1  one-cycle pulse on expiry.
REQ-012 load_err  output  1  one-cycle pulse on a rejected load.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSED and EXPIRED.
REQ-014 All outputs SHALL be registered; each update SHALL occur on the clk edge that samples the causing input (latency 1 cycle).
REQ-015 Priority per cycle SHALL be reset > load > pause > start > tick.
REQ-016 Valid load (every nibble <= 9) in any state: q <= load_val, state <= IDLE, no other action that cycle.
REQ-017 Invalid load (any nibble > 9): q and state unchanged, load_err pulses for 1 cycle.
REQ-018 IDLE or PAUSED with start=1 and q != 0: state <= RUN.
REQ-019 IDLE or PAUSED with start=1 and q == 0: state <= EXPIRED, done pulses for 1 cycle.
REQ-020 RUN with pause=1: state <= PAUSED; any tick in that cycle is ignored, so q holds.
REQ-021 pause outside RUN SHALL be ignored; start in RUN or EXPIRED SHALL be ignored.
REQ-022 RUN with tick=1 and q != 0: q SHALL decrement by one in BCD.
  - Digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
  - No nibble ever holds a value above 9.
REQ-023 RUN with tick=1 and q == 1: q <= 0, state <= EXPIRED, done = 1 in the same cycle q first reads 0.
REQ-024 tick=0 SHALL leave q unchanged in every state; tick SHALL be ignored in IDLE, PAUSED and EXPIRED.
REQ-025 EXPIRED SHALL hold q = 0 and running = 0 until a valid load; done SHALL NOT re-pulse while in EXPIRED.
REQ-026 done and load_err SHALL never be high for two consecutive cycles unless re-triggered by a new qualifying event.
REQ-027 Any digit sequence SHALL count down to 0 and SHALL NOT wrap: the maximum preset (all 9s) reaches 0 after 10^DIGITS - 1 ticks.

Reset
REQ-028 reset SHALL force q = 0, state = IDLE, running = 0, done = 0 and load_err = 0 on the next clk edge, overriding all other inputs.
REQ-029 reset asserted mid-countdown SHALL abandon the count with no done pulse; after reset, start alone SHALL go to EXPIRED per REQ-019.

Verification (DIGITS = 3)
REQ-030 Load 0x105, start, 6 ticks.
  - q sequence: 104, 103, 102, 101, 100, 099.
  - Borrow across two digits is checked at 100 -> 099.
REQ-031 Load 0x002, start, 2 ticks.
  - q = 001, then 000 with done = 1 for exactly 1 cycle.
  - Further ticks: q stays 000, running = 0, no more done pulses.
REQ-032 Load 0x1A3.
  - load_err = 1 for 1 cycle.
  - q and state unchanged.
REQ-033 Load 0x050, start, tick.
  - q = 049.
  - Then pause and tick in the same cycle: q stays 049, state PAUSED.
  - Ticks while paused: no change.
  - Start, tick: q = 048.
REQ-034 Load 0x999, start, tick every cycle.
  - done is asserted after exactly 999 ticks.
  - A reset asserted mid-run at q = 500 gives q = 000, IDLE, no done pulse.
REQ-035 Simultaneous load and start with load_val = 0x010.
  - Load wins: q = 010, state IDLE.
  - Next-cycle start enters RUN.
